// File: rtl/buzzer_music_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : buzzer_music_pkg                                                |
// | Purpose  : Shared constants for the buzzer music player: FSM encoding,     |
// |            tone half-periods (C4..B5 at 50 MHz), pitch codes and the       |
// |            song ROM image (4 songs x 32 entries of {pitch, beats}).        |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package buzzer_music_pkg;

    // Player states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_TONE  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int HALF_W = 17;

    localparam logic [3:0] PITCH_REST = 4'd0;
    localparam logic [3:0] PITCH_END  = 4'd15;

    // Half-period in HCLK cycles = 25e6 / f, with f rounded to whole Hz.
    // Entries 0 (rest) and 15 (end) never produce a tone.
    localparam logic [HALF_W-1:0] PITCH_HALF [0:15] = '{
        17'd0,
        17'd95420, 17'd85034, 17'd75758, 17'd71633, 17'd63776, 17'd56818, 17'd50607,
        17'd47801, 17'd42589, 17'd37936, 17'd35817, 17'd31888, 17'd28409, 17'd25304,
        17'd0
    };

    // Address = {song[1:0], note_index[4:0]}; entry = {pitch[7:4], beats[3:0]}.
    // Song 0: short chime (C4 one beat, two-beat rest, end).
    // Song 1: 32 one-beat C4 pulses (full-length alarm, exercises no-wrap end).
    // Song 2: ascending C major scale.  Song 3: opening of a nursery tune.
    localparam logic [7:0] SONG_ROM [0:127] = '{
        8'h10, 8'h01, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
        8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
        8'h11, 8'h21, 8'h31, 8'h41, 8'h51, 8'h61, 8'h71, 8'h83, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0,
        8'h11, 8'h11, 8'h51, 8'h51, 8'h61, 8'h61, 8'h53, 8'h41, 8'h41, 8'h31, 8'h31, 8'h21, 8'h21, 8'h13, 8'hF0, 8'hF0,
        8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0
    };

endpackage
`default_nettype wire

// File: rtl/buzzer_music_player_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : buzzer_note_rom                                                 |
// | Purpose  : 128 x 8 song ROM with a registered (1-cycle latency) read port. |
// | Ports    : HCLK   - clock                                                  |
// |            i_addr - {song, note_index} read address                        |
// |            o_data - {pitch, beats}, valid the cycle after i_addr           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module buzzer_note_rom (
    input  logic       HCLK,
    input  logic [6:0] i_addr,
    output logic [7:0] o_data
);
    import buzzer_music_pkg::*;

    logic [7:0] r_data;

    // Plain registered read with no reset so it maps onto block ROM.
    always_ff @(posedge HCLK) begin
        r_data <= SONG_ROM[i_addr];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/buzzer_music_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : buzzer_music_player                                             |
// | Purpose  : Plays one of four ROM songs as a square wave on a buzzer pin.   |
// |            A music_start strobe starts a song, stops it (same select) or   |
// |            restarts with another song (different select).                 |
// | Ports    : HCLK, HRESETn    - clock, async active-low reset                |
// |            music_select[1:0]- song number, sampled with music_start        |
// |            music_start      - one-cycle start/stop strobe                  |
// |            buzzer           - registered square wave, 0 when silent        |
// |            busy             - high whenever playback is in progress        |
// |            note_index[4:0]  - ROM entry currently playing                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module buzzer_music_player #(
    parameter int BEAT_CYCLES = 6_250_000,
    parameter int GAP_CYCLES  = 625_000,
    parameter int PITCH_SHIFT = 0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [1:0] music_select,
    input  logic       music_start,
    output logic       buzzer,
    output logic       busy,
    output logic [4:0] note_index
);
    import buzzer_music_pkg::*;

    localparam int c_TIMER_W = $clog2(16 * BEAT_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_GAP = c_TIMER_W'(GAP_CYCLES);

    logic [1:0]           r_state;
    logic [1:0]           r_song;
    logic [4:0]           r_idx;
    logic [c_TIMER_W-1:0] r_timer;
    logic [HALF_W-1:0]    r_half;
    logic [HALF_W-1:0]    r_half_reload;
    logic                 r_is_rest;
    logic                 r_buzzer;

    logic [1:0]           w_state_nxt;
    logic [1:0]           w_song_nxt;
    logic [4:0]           w_idx_nxt;
    logic [7:0]           w_rom_data;
    logic [3:0]           w_rom_pitch;
    logic [3:0]           w_rom_beats;
    logic [HALF_W-1:0]    w_half_shift;
    logic [HALF_W-1:0]    w_half_load;
    logic [c_TIMER_W-1:0] w_timer_load;
    logic                 w_strobe_busy;

    // The ROM is addressed with the *next* song/index so that the entry is
    // already on the ROM output during the single FETCH cycle.
    buzzer_note_rom u_rom (
        .HCLK   (HCLK),
        .i_addr ({w_song_nxt, w_idx_nxt}),
        .o_data (w_rom_data)
    );

    assign w_rom_pitch   = w_rom_data[7:4];
    assign w_rom_beats   = w_rom_data[3:0];
    assign w_strobe_busy = music_start && (r_state != ST_IDLE);

    // Counter reload values for the fetched note. A half-period that shifts
    // down to 0 behaves like 1, i.e. the buzzer toggles every cycle.
    always_comb begin
        w_half_shift = PITCH_HALF[w_rom_pitch] >> PITCH_SHIFT;
        w_half_load  = (w_half_shift == '0) ? '0 : (w_half_shift - 17'd1);
        w_timer_load = c_TIMER_W'((int'(w_rom_beats) + 1) * BEAT_CYCLES - 1);
    end

    // Next state / song / index. A strobe while busy overrides every
    // internal transition in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_song_nxt  = r_song;
        w_idx_nxt   = r_idx;
        if (r_state == ST_IDLE) begin
            if (music_start) begin
                w_state_nxt = ST_FETCH;
                w_song_nxt  = music_select;
                w_idx_nxt   = 5'd0;
            end
        end else if (music_start) begin
            if (music_select == r_song) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_FETCH;
                w_song_nxt  = music_select;
                w_idx_nxt   = 5'd0;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    w_state_nxt = (w_rom_pitch == PITCH_END) ? ST_IDLE : ST_TONE;
                end
                ST_TONE: begin
                    if (r_timer == c_GAP) begin
                        w_state_nxt = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_timer == '0) begin
                        if (r_idx == 5'd31) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_FETCH;
                            w_idx_nxt   = r_idx + 5'd1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= ST_IDLE;
            r_song        <= 2'd0;
            r_idx         <= 5'd0;
            r_timer       <= '0;
            r_half        <= '0;
            r_half_reload <= '0;
            r_is_rest     <= 1'b0;
            r_buzzer      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_song  <= w_song_nxt;
            r_idx   <= w_idx_nxt;
            if (w_strobe_busy) begin
                r_buzzer <= 1'b0;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        r_buzzer      <= 1'b0;
                        r_timer       <= w_timer_load;
                        r_half        <= w_half_load;
                        r_half_reload <= w_half_load;
                        r_is_rest     <= (w_rom_pitch == PITCH_REST);
                    end
                    ST_TONE: begin
                        r_timer <= r_timer - c_TIMER_W'(1);
                        if (r_timer == c_GAP) begin
                            r_buzzer <= 1'b0;
                        end else if (!r_is_rest) begin
                            if (r_half == '0) begin
                                r_buzzer <= ~r_buzzer;
                                r_half   <= r_half_reload;
                            end else begin
                                r_half <= r_half - 17'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        r_buzzer <= 1'b0;
                        if (r_timer != '0) begin
                            r_timer <= r_timer - c_TIMER_W'(1);
                        end
                    end
                    default: r_buzzer <= 1'b0;
                endcase
            end
        end
    end

    assign buzzer     = r_buzzer;
    assign busy       = (r_state != ST_IDLE);
    assign note_index = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_music_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_buzzer_music_player                                          |
// | Purpose  : Self-checking bench for buzzer_music_player with short beats.   |
// |            Expected outputs come from a per-cycle trace built from the     |
// |            song rules (notes expanded into FETCH/TONE/GAP cycles).         |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_buzzer_music_player;

    localparam int BEAT  = 16;
    localparam int GAP   = 4;
    localparam int SHIFT = 14;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic [1:0] music_select = 2'd0;
    logic       music_start = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [4:0] note_index;

    buzzer_music_player #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .PITCH_SHIFT (SHIFT)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .music_select (music_select),
        .music_start  (music_start),
        .buzzer       (buzzer),
        .busy         (busy),
        .note_index   (note_index)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        bit         bz;
        bit         busy;
        logic [4:0] idx;
    } exp_t;

    typedef struct {
        bit         start;
        logic [1:0] sel;
        int         n;
        bit         bz;
        bit         busy;
        logic [4:0] idx;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];
    exp_t m_cur;
    logic [1:0] m_song;

    // Test song table: song 0 = C4/1 beat, rest/2 beats, END; song 1 = 32 x C4/1 beat.
    function automatic logic [7:0] song_entry(input int s, input int i);
        if (s == 0) begin
            if (i == 0) return 8'h10;
            if (i == 1) return 8'h01;
            return 8'hF0;
        end
        if (s == 1) return 8'h10;
        return 8'hF0;
    endfunction

    function automatic int half_of(input int p);
        int h;
        h = (p == 1) ? (95420 >> SHIFT) : 0;
        return (h == 0) ? 1 : h;
    endfunction

    // Expand a song into the exact per-cycle output trace following a start strobe.
    task automatic build_song(input int s);
        q.delete();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] e;
            int p, b, len, h;
            e = song_entry(s, i);
            p = int'(e[7:4]);
            b = int'(e[3:0]);
            q.push_back('{1'b0, 1'b1, 5'(i)});
            if (p == 15) break;
            len = (b + 1) * BEAT - GAP;
            h   = half_of(p);
            for (int k = 0; k < len; k++)
                q.push_back('{(p != 0) ? 1'((k / h) % 2) : 1'b0, 1'b1, 5'(i)});
            for (int k = 0; k < GAP; k++)
                q.push_back('{1'b0, 1'b1, 5'(i)});
        end
    endtask

    task automatic model_edge(input bit st, input logic [1:0] sel);
        if (st && m_cur.busy && sel == m_song) begin
            q.delete();
            m_cur.bz   = 1'b0;
            m_cur.busy = 1'b0;
        end else if (st) begin
            m_song = sel;
            build_song(int'(sel));
            m_cur = q.pop_front();
        end else if (q.size() > 0) begin
            m_cur = q.pop_front();
        end else begin
            m_cur.bz   = 1'b0;
            m_cur.busy = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual(bz,busy,idx)=%b,%b,%0d required=%b,%b,%0d",
                     name, cyc, act[6], act[5], act[4:0], req[6], req[5], req[4:0]);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model at posedge,
    // compare DUT against the model 1 time unit later.
    task automatic step(input bit st, input logic [1:0] sel);
        @(negedge HCLK);
        music_start  = st;
        music_select = sel;
        @(posedge HCLK);
        cyc++;
        if (HRESETn) model_edge(st, sel);
        #1;
        chk("model", {buzzer, busy, note_index}, {m_cur.bz, m_cur.busy, m_cur.idx});
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{1'b1, 2'd0,  1, 1'b0, 1'b1, 5'd0};  // strobe -> FETCH
        vecs[1] = '{1'b0, 2'd0,  5, 1'b0, 1'b1, 5'd0};  // TONE, first half-period
        vecs[2] = '{1'b0, 2'd0,  5, 1'b1, 1'b1, 5'd0};
        vecs[3] = '{1'b0, 2'd0,  2, 1'b0, 1'b1, 5'd0};
        vecs[4] = '{1'b0, 2'd0,  4, 1'b0, 1'b1, 5'd0};  // GAP
        vecs[5] = '{1'b0, 2'd0,  1, 1'b0, 1'b1, 5'd1};  // FETCH rest
        vecs[6] = '{1'b0, 2'd0, 28, 1'b0, 1'b1, 5'd1};  // rest TONE
        vecs[7] = '{1'b0, 2'd0,  4, 1'b0, 1'b1, 5'd1};  // GAP
        vecs[8] = '{1'b0, 2'd0,  1, 1'b0, 1'b1, 5'd2};  // FETCH END
        vecs[9] = '{1'b0, 2'd0, 10, 1'b0, 1'b0, 5'd2};  // idle

        m_cur  = '{1'b0, 1'b0, 5'd0};
        m_song = 2'd0;

        // Reset, then 100 idle cycles
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset", {buzzer, busy, note_index}, 7'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 2'd0);
            chk("idle", {buzzer, busy, note_index}, 7'b0);
        end

        // Song 0 from the vector table
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < vecs[r].n; c++) begin
                step((c == 0) ? vecs[r].start : 1'b0, vecs[r].sel);
                chk($sformatf("vec%0d", r), {buzzer, busy, note_index},
                    {vecs[r].bz, vecs[r].busy, vecs[r].idx});
            end
        end

        // Song 1 full length: 32 notes x 17 cycles, no wrap
        step(1'b1, 2'd1);
        repeat (542) step(1'b0, 2'd0);
        step(1'b0, 2'd0);
        chk("song1_last_gap", {buzzer, busy, note_index}, {1'b0, 1'b1, 5'd31});
        step(1'b0, 2'd0);
        chk("song1_end", {buzzer, busy, note_index}, {1'b0, 1'b0, 5'd31});
        repeat (5) step(1'b0, 2'd0);

        // Stop: same select while buzzer is high
        step(1'b1, 2'd1);
        repeat (6) step(1'b0, 2'd0);
        chk("pre_stop", {buzzer, busy, note_index}, {1'b1, 1'b1, 5'd0});
        step(1'b1, 2'd1);
        chk("stop", {buzzer, busy, note_index}, 7'b0);
        repeat (5) step(1'b0, 2'd0);

        // Restart: song 1 at note 3, strobe song 0
        step(1'b1, 2'd1);
        repeat (53) step(1'b0, 2'd0);
        chk("pre_restart", {1'b0, busy, note_index}, {1'b0, 1'b1, 5'd3});
        step(1'b1, 2'd0);
        chk("restart", {buzzer, busy, note_index}, {1'b0, 1'b1, 5'd0});
        repeat (6) step(1'b0, 2'd0);
        chk("restart_tone", {buzzer, busy, note_index}, {1'b1, 1'b1, 5'd0});
        repeat (70) step(1'b0, 2'd0);

        // Asynchronous reset in the middle of a TONE
        step(1'b1, 2'd1);
        repeat (40) step(1'b0, 2'd0);
        chk("pre_reset", {buzzer, busy, note_index}, {1'b1, 1'b1, 5'd2});
        #2;
        HRESETn = 1'b0;
        #1;
        chk("async_reset", {buzzer, busy, note_index}, 7'b0);
        q.delete();
        m_cur = '{1'b0, 1'b0, 5'd0};
        repeat (2) step(1'b0, 2'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'd1);
            chk("post_reset", {buzzer, busy, note_index}, 7'b0);
        end

        // Random strobes against the trace model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 39) == 0), 2'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/buzzer_music_player.md
# buzzer_music_player

Playback engine at the far end of the AHB-Lite buzzer-music register. It consumes the one-cycle `music_start` strobe and the 2-bit `music_select` code that the bus slave emits on a write. It plays one of four songs from an on-chip note ROM on a single square-wave `buzzer` pin. It is a standalone peripheral-side block in the `HCLK` domain, with no bus interface of its own.

## Interface
Parameters:
- `BEAT_CYCLES`, default 6_250_000: clock cycles per beat (125 ms at 50 MHz).
- `GAP_CYCLES`, default 625_000: silent tail at the end of every note. Must satisfy 0 < GAP_CYCLES < BEAT_CYCLES.
- `PITCH_SHIFT`, default 0: right-shift applied to every tone half-period. Used only to shrink tones in simulation.

Ports:
- `HCLK` in 1: system clock.
- `HRESETn` in 1: reset. One clock; reset is asynchronous and active-low.
- `music_select` in 2: song number, sampled only when `music_start`=1.
- `music_start` in 1: single-cycle start/stop strobe.
- `buzzer` out 1: registered square wave; 0 when silent.
- `busy` out 1: 1 whenever state ≠ IDLE.
- `note_index` out 5: index of the ROM entry currently playing.

## Operation
- ROM layout: 4 songs × 32 entries, 8 bits per entry: `{pitch[7:4], beats[3:0]}`.
  - pitch 0 = rest.
  - pitch 1..14 index `PITCH_HALF[pitch]`.
  - pitch 15 = END.
  - Note length = (beats+1) beats, i.e. 1..16 beats.
- States: IDLE, FETCH, TONE, GAP.
- IDLE:
  - On `music_start`=1, latch `song`=`music_select`, set `note_index`=0, go to FETCH.
- FETCH (exactly 1 cycle): synchronous ROM read at address `{song, note_index}`.
  - If pitch=15, go to IDLE.
  - Otherwise load `note_timer`=(beats+1)*BEAT_CYCLES−1 and `half_cnt`=(PITCH_HALF[pitch]>>PITCH_SHIFT)−1, set `buzzer`=0, and go to TONE.
- TONE:
  - `note_timer` decrements every cycle.
  - For pitch≠0, `half_cnt` decrements; on reaching 0, `buzzer` toggles and `half_cnt` reloads.
  - For pitch=0, `buzzer` stays 0.
  - When `note_timer` reaches GAP_CYCLES, force `buzzer`=0 and go to GAP.
- GAP:
  - `buzzer`=0 and `note_timer` keeps decrementing.
  - At 0: if `note_index`=31, go to IDLE (end of song, no wrap). Otherwise increment `note_index` and go to FETCH.
- Strobe while busy:
  - Same select as the latched `song`: stop, i.e. go to IDLE next cycle with `buzzer`=0.
  - Different select: restart, i.e. latch the new song, set `note_index`=0, go to FETCH.
  - Applies in every non-IDLE state and takes priority over all internal transitions in that cycle.
- Shifted half-periods that evaluate to 0 are treated as 1, so `buzzer` toggles every cycle.

## Timing
- Reset values: `buzzer`=0, `busy`=0, `note_index`=0, state=IDLE; all counters 0.
- HRESETn asserted mid-song aborts playback immediately (asynchronous). After release the block waits in IDLE for a new strobe.
- Strobe sampled at edge N → FETCH during N+1 → TONE from N+2. The first `buzzer` toggle follows PITCH_HALF>>PITCH_SHIFT cycles after entering TONE.
- Per-note time, FETCH excluded: TONE lasts (beats+1)*BEAT_CYCLES−GAP_CYCLES cycles, then GAP lasts GAP_CYCLES cycles. Each note adds one extra FETCH cycle.
- `busy` drops the cycle after the final GAP ends, after END is fetched, or after a stop strobe.
- `note_timer` width: ceil(log2(16*BEAT_CYCLES)), 27 bits at default.
- `half_cnt` width: 17 bits.

## Structure
- Package `buzzer_music_pkg`:
  - state enum;
  - `PITCH_HALF[1..14]` (C4..B5 half-periods at 50 MHz, e.g. C4=95_420);
  - `PITCH_REST`=0, `PITCH_END`=15;
  - `SONG_ROM[0:127]` contents.
- One sub-module, `buzzer_note_rom`: 128×8 synchronous-read ROM, 1-cycle latency, initialised from the package.

## Test plan
Bench parameters: BEAT_CYCLES=16, GAP_CYCLES=4, PITCH_SHIFT=14, with a test ROM where song 0 = {C4,beats 0},{rest,beats 1},{END} and song 1 = 32 entries of {C4,beats 0}.
- Reset, then idle 100 cycles → `buzzer`=0, `busy`=0, `note_index`=0 throughout.
- Strobe select=0 at cycle N → `busy`=1 at N+1. `buzzer` toggles every 5 cycles (95_420>>14) for 12 cycles, is low 4 cycles, then stays low for the 32-cycle rest. `busy`=0 after END.
- Strobe select=1 → `note_index` steps 0..31, each note taking 17 cycles. IDLE follows the GAP of entry 31 with no wrap to 0.
- Song 1 playing, strobe select=1 → `buzzer`=0 and `busy`=0 the next cycle.
- Song 1 playing, strobe select=0 → `note_index`=0, FETCH next cycle, song 0 timing restarts.
- Assert HRESETn low mid-TONE → `buzzer`, `busy` and `note_index` go to 0 without waiting for a clock edge. After release, no playback until a new strobe.
